// File: rtl/zpu_config.sv
// Shared ZPU configuration: word geometry, IO decode bit and memory-controller
// state encoding used by zpu_mem_ctrl and its timer.
package zpu_config;

   localparam int wordSize  = 32;
   localparam int wordBytes = 4;
   localparam int ioBit     = 27;

   localparam int               IO_BIT_DEF     = 27;
   localparam int               IO_TIMEOUT_DEF = 255;
   localparam logic [31:0]      ERR_DATA_DEF   = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAM_RD = 2'd1,
      ST_IO_WAIT = 2'd2
   } mc_state_t;

endpackage

// File: rtl/zpu_mem_ctrl_if.sv
// ZPU core memory bus: request side driven by the core (master), busy and
// read-data returned by the memory controller (slave).
interface zpu_mem_ctrl_if #(
   parameter int ADDR_W     = 28,
   parameter int WORD_SIZE  = 32,
   parameter int WORD_BYTES = 4
);
   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_readEnable;
   logic                  mem_writeEnable;
   logic [WORD_SIZE-1:0]  mem_write;
   logic [WORD_BYTES-1:0] mem_writeMask;
   logic                  mem_busy;
   logic [WORD_SIZE-1:0]  mem_read;

   modport master (
      output mem_addr, mem_readEnable, mem_writeEnable, mem_write, mem_writeMask,
      input  mem_busy, mem_read
   );

   modport slave (
      input  mem_addr, mem_readEnable, mem_writeEnable, mem_write, mem_writeMask,
      output mem_busy, mem_read
   );
endinterface

// File: rtl/zpu_io_timer.sv
// 8-bit clear/increment timer bounding IO accesses; tc_o flags the increment
// that brings the count up to TERM.
module zpu_io_timer #(
   parameter int TERM = 255
) (
   input  logic clk,
   input  logic areset,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);
   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i)
         count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign tc_o = inc_i & (count_d == 8'(TERM));
endmodule

// File: rtl/zpu_mem_ctrl.sv
// ZPU memory-bus controller: decodes core accesses onto DPRAM or IO space,
// generates busy / read-data return, IO timeout and the post-reset core enable.
module zpu_mem_ctrl
   import zpu_config::*;
#(
   parameter int                   WORD_SIZE  = wordSize,
   parameter int                   WORD_BYTES = wordBytes,
   parameter int                   ADDR_W     = 28,
   parameter int                   IO_BIT     = IO_BIT_DEF,
   parameter int                   IO_TIMEOUT = IO_TIMEOUT_DEF,
   parameter logic [WORD_SIZE-1:0] ERR_DATA   = ERR_DATA_DEF
) (
   input  logic                  clk,
   input  logic                  areset,
   output logic                  enable,
   zpu_mem_ctrl_if.slave         zpu,
   output logic [ADDR_W-1:0]     dram_addr,
   output logic                  dram_re,
   output logic                  dram_we,
   output logic [WORD_SIZE-1:0]  dram_wdata,
   output logic [WORD_BYTES-1:0] dram_mask,
   input  logic [WORD_SIZE-1:0]  dram_rdata,
   output logic [ADDR_W-1:0]     io_addr,
   output logic                  io_re,
   output logic                  io_we,
   output logic [WORD_SIZE-1:0]  io_wdata,
   input  logic [WORD_SIZE-1:0]  io_rdata,
   input  logic                  io_ack,
   output logic                  bus_err
);
   mc_state_t             state_q;
   logic                  enable_q;
   logic [ADDR_W-1:0]     dram_addr_q, io_addr_q;
   logic [WORD_SIZE-1:0]  dram_wdata_q, io_wdata_q, mem_read_q;
   logic [WORD_BYTES-1:0] dram_mask_q;
   logic                  dram_re_q, dram_we_q, io_re_q, io_we_q, bus_err_q;
   logic                  io_rd_q, rd_bypass_q;

   logic req, accept, acc_rd, acc_io, io_tc;

   // Read wins over write when both enables are high.
   assign req    = (zpu.mem_readEnable | zpu.mem_writeEnable) & enable_q;
   assign accept = (state_q == ST_IDLE) & req;
   assign acc_rd = zpu.mem_readEnable;
   assign acc_io = zpu.mem_addr[IO_BIT];

   assign zpu.mem_busy = (accept & (acc_rd | acc_io)) | (state_q != ST_IDLE);
   // DPRAM data appears the cycle after its strobe; present it directly then hold it.
   assign zpu.mem_read = rd_bypass_q ? dram_rdata : mem_read_q;

   zpu_io_timer #(
      .TERM (IO_TIMEOUT)
   ) u_io_timer (
      .clk    (clk),
      .areset (areset),
      .clr_i  (accept & acc_io),
      .inc_i  (state_q == ST_IO_WAIT),
      .tc_o   (io_tc)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         enable_q     <= 1'b0;
         dram_addr_q  <= '0;
         dram_wdata_q <= '0;
         dram_mask_q  <= '0;
         dram_re_q    <= 1'b0;
         dram_we_q    <= 1'b0;
         io_addr_q    <= '0;
         io_wdata_q   <= '0;
         io_re_q      <= 1'b0;
         io_we_q      <= 1'b0;
         io_rd_q      <= 1'b0;
         bus_err_q    <= 1'b0;
         mem_read_q   <= '0;
         rd_bypass_q  <= 1'b0;
      end else begin
         enable_q    <= 1'b1;
         dram_re_q   <= 1'b0;
         dram_we_q   <= 1'b0;
         io_re_q     <= 1'b0;
         io_we_q     <= 1'b0;
         bus_err_q   <= 1'b0;
         rd_bypass_q <= 1'b0;
         if (rd_bypass_q)
            mem_read_q <= dram_rdata;

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (acc_io) begin
                     io_addr_q  <= zpu.mem_addr;
                     io_wdata_q <= zpu.mem_write;
                     io_re_q    <= acc_rd;
                     io_we_q    <= ~acc_rd;
                     io_rd_q    <= acc_rd;
                     state_q    <= ST_IO_WAIT;
                  end else begin
                     dram_addr_q  <= zpu.mem_addr;
                     dram_wdata_q <= zpu.mem_write;
                     dram_mask_q  <= zpu.mem_writeMask;
                     dram_re_q    <= acc_rd;
                     dram_we_q    <= ~acc_rd;
                     if (acc_rd)
                        state_q <= ST_DRAM_RD;
                  end
               end
            end

            ST_DRAM_RD: begin
               rd_bypass_q <= 1'b1;
               state_q     <= ST_IDLE;
            end

            ST_IO_WAIT: begin
               // An ack on the terminal-count cycle still completes normally.
               if (io_ack) begin
                  if (io_rd_q)
                     mem_read_q <= io_rdata;
                  state_q <= ST_IDLE;
               end else if (io_tc) begin
                  if (io_rd_q)
                     mem_read_q <= ERR_DATA;
                  bus_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign enable     = enable_q;
   assign dram_addr  = dram_addr_q;
   assign dram_re    = dram_re_q;
   assign dram_we    = dram_we_q;
   assign dram_wdata = dram_wdata_q;
   assign dram_mask  = dram_mask_q;
   assign io_addr    = io_addr_q;
   assign io_re      = io_re_q;
   assign io_we      = io_we_q;
   assign io_wdata   = io_wdata_q;
   assign bus_err    = bus_err_q;
endmodule

// File: doc/zpu_mem_ctrl.md
Name: zpu_mem_ctrl

Overview:
Memory-bus controller between zpu_core and its two slave regions: the on-chip DPRAM and the IO space.
- Decodes each ZPU access on the IO bit.
- Drives registered strobes to the selected slave.
- Generates in_mem_busy and the mem_read return mux.
- Bounds IO accesses with a timeout.
- Generates the core enable after reset.
It replaces the ad-hoc glue logic in top-levels and benches.

Parameters:
WORD_SIZE, 32, data width
WORD_BYTES, 4, write-mask width (WORD_SIZE/8)
ADDR_W, 28, ZPU byte-address width
IO_BIT, 27, address bit selecting IO (1) or DPRAM (0)
IO_TIMEOUT, 255, max cycles waiting for io_ack; 8-bit counter
ERR_DATA, 32'hDEADBEEF, read data returned on IO timeout

Ports:
clk  in  1  system clock, rising edge
areset  in  1  asynchronous reset, active-high
enable  out  1  core enable; 0 in reset, 1 from first clk edge after release
mem_addr  in  ADDR_W  ZPU address
mem_readEnable  in  1  ZPU read request pulse
mem_writeEnable  in  1  ZPU write request pulse
mem_write  in  WORD_SIZE  ZPU write data
mem_writeMask  in  WORD_BYTES  ZPU byte mask
mem_busy  out  1  to zpu_core in_mem_busy
mem_read  out  WORD_SIZE  read data to ZPU
dram_addr  out  ADDR_W  DPRAM address (registered)
dram_re / dram_we  out  1 each  DPRAM strobes, one-cycle pulses
dram_wdata  out  WORD_SIZE  DPRAM write data
dram_mask  out  WORD_BYTES  DPRAM byte mask
dram_rdata  in  WORD_SIZE  DPRAM data, valid one cycle after dram_re
io_addr  out  ADDR_W  IO address (registered)
io_re / io_we  out  1 each  IO strobes, one-cycle pulses
io_wdata  out  WORD_SIZE  IO write data
io_rdata  in  WORD_SIZE  IO read data, valid with io_ack
io_ack  in  1  IO completion, one cycle, any latency >= 1
bus_err  out  1  one-cycle pulse on IO timeout

Behaviour:
Reset values:
- All outputs 0, including enable, mem_busy and mem_read.
- FSM in IDLE; timeout counter 0.

FSM states: IDLE, DRAM_RD, IO_WAIT.

Request acceptance:
- A request is accepted only in IDLE.
- A request is (re|we) & enable. If re and we are both high, the read wins and the write is dropped.
- mem_busy = (IDLE & accepted request that is a read or any IO access) | (state != IDLE). It is combinational, so busy is high in the request cycle N.
- Accepted request registers addr, data and mask into the chosen slave's outputs. The slave strobe is high in cycle N+1 only.

DRAM write: strobe at N+1; busy stays 0; FSM remains IDLE (fire-and-forget).

DRAM read:
- IDLE -> DRAM_RD.
- At N+2, mem_read <= dram_rdata (registered); FSM -> IDLE.
- busy is high in N and N+1, low from N+2 when data is valid.

IO read/write:
- IDLE -> IO_WAIT; counter cleared.
- In IO_WAIT, counter increments each cycle.
- On io_ack: for a read, mem_read <= io_rdata; FSM -> IDLE next edge; busy low the cycle after ack.
- io_ack in IDLE is ignored.
- If the counter reaches IO_TIMEOUT without ack: for a read, mem_read <= ERR_DATA; bus_err pulses; FSM -> IDLE.
- io_ack in the same cycle the counter reaches IO_TIMEOUT: the ack wins, no bus_err.

mem_read holds its last value until the next read completes.

Requests while busy: a ZPU protocol violation; ignored, no state change.

areset mid-access: immediate return to reset values. Any strobe in flight is cut; a slave may see a truncated access.

Decomposition:
- zpu_config package gets the state encoding constants (ST_IDLE, ST_DRAM_RD, ST_IO_WAIT) and the IO_BIT/ERR_DATA defaults, alongside the existing wordSize/wordBytes/ioBit.
- One sub-module: zpu_io_timer, the 8-bit clear/increment/terminal-count timer.

Test Plan:
1. Reset: hold areset 100 ns -> all outputs 0; enable=1 one clk after release.
2. DRAM write to 0x0000100, data 0x12345678, mask 4'hF -> dram_we pulse at N+1 with same addr/data; mem_busy never high.
3. DRAM read from 0x0000200, model returns 0xCAFEF00D -> busy high N and N+1; mem_read=0xCAFEF00D at N+2; busy low at N+2.
4. IO read to 0x80A000C, io_ack with io_rdata=0x100 after 5 cycles -> io_re at N+1; busy high until the cycle after ack; mem_read=0x100; bus_err 0.
5. IO write 0x41 to 0x80A000C with no ack -> bus_err pulse after 255 IO_WAIT cycles; busy then drops; FSM returns to IDLE; the next DRAM read succeeds.
6. io_ack on the terminal-count cycle -> data taken, bus_err 0. areset asserted during IO_WAIT -> busy 0 immediately, io_re/io_we 0.
